power_window_accumulator: RTL
=============================

Name: power_window_accumulator

Overview:
- Consumes the signed, mean-removed sample stream and its per-sample valid strobe from the DC-removal stage.
- Over each window of 2^LOG2_N accepted samples it computes the mean-square value (signal power) and the peak absolute value.
- Results go to the readout/averaging logic with a one-cycle data_valid pulse.
- After each enable it discards a programmable number of settling samples while the upstream mean estimate fills.

Parameters:
LOG2_N, 5, window length exponent; window N = 2^LOG2_N samples; legal range 1..10
SETTLE, 32, samples discarded after enable rises before the first window starts; 0 = no discard

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  level; 1 = run, 0 = idle and discard partial window
data_in  input  32  signed sample from DC-removal stage
CE  input  1  sample strobe; data_in valid in any cycle CE=1; may be high every cycle
mean_sq  output  32  unsigned mean of squares of the last completed window, saturated
peak_abs  output  17  unsigned max |sample| of the last completed window
data_valid  output  1  one-cycle pulse when mean_sq/peak_abs update
clip  output  1  sticky; set when any accepted data_in lies outside [-65536, 65535]
busy  output  1  1 when state is SETTLING or RUN

Behaviour:
- Reset: when reset=1 at a clock edge:
  - mean_sq=0, peak_abs=0, data_valid=0, clip=0, busy=0.
  - State goes to IDLE; all pipeline valid bits, the accumulator, the peak register and both counters are cleared.
  - reset has priority over every other input.
- FSM states IDLE, SETTLING, RUN:
  - IDLE: busy=0. On enable=1, go to SETTLING if SETTLE>0, otherwise to RUN. In the same cycle clear the settle count, sample count, accumulator, peak register and clip.
  - SETTLING: each CE=1 increments the settle count; the sample is not fed to the pipeline. When the SETTLE-th sample is seen, go to RUN.
  - RUN: each CE=1 injects the sample into the pipeline.
  - enable=0 in SETTLING or RUN: go to IDLE on the next edge. Pipeline valid bits are cleared, the partial window is discarded, and no data_valid is produced for it. mean_sq and peak_abs hold their last values.
- Pipeline (RUN only; fully pipelined, accepts CE every cycle):
  - S1: saturate data_in to 17-bit signed [-65536, 65535]. If saturation occurs, set clip. Register the saturated value and the last-of-window flag, which is true when the sample count equals N-1. The sample count wraps N-1 -> 0.
  - S2: register the 34-bit unsigned square and the 17-bit |x|.
  - S3: the accumulator (34+LOG2_N bits) adds the square, and the peak register takes max(peak, |x|).
    - If the flag is set: mean_sq <= min((acc + sq) >> LOG2_N, 0xFFFFFFFF), peak_abs <= max(peak, |x|), and data_valid <= 1.
    - In that same cycle the accumulator and peak restart at 0, so the next sample begins a fresh window with none lost.
- Latency: data_valid=1 in the 3rd cycle after the cycle in which the Nth sample's CE is sampled.
  - Example: CE for the Nth sample is high in cycle t, so data_valid=1 in cycle t+3 only.
  - Outputs are stable from that cycle until the next update.
- Width rules:
  - Only the square of -65536 (2^32) can yield mean 2^32; it saturates to 0xFFFFFFFF.
  - |−65536| = 65536 fits peak_abs.
- Simultaneous events:
  - CE=1 in the IDLE->SETTLING/RUN transition cycle is ignored.
  - enable=0 in a cycle with a completing window in S3: the result is still published.
  - enable=0 with CE=1: the sample is dropped.
- clip is cleared only by reset or by the enable-rise transition out of IDLE.

Test Plan:
- LOG2_N=5, SETTLE=0: 32 CE samples of +100 back-to-back -> single data_valid 3 cycles after the 32nd CE; mean_sq=10000, peak_abs=100, clip=0.
- SETTLE=4: 4 samples of 30000, then 32 alternating +/-200 with CE every 3rd cycle -> the first four are ignored; mean_sq=40000, peak_abs=200.
- 96 continuous CE samples (three windows of 10, -20, 30) -> data_valid pulses exactly 32 cycles apart; mean_sq = 100, 400, 900; no sample lost across boundaries.
- 32 samples of data_in=-100000 -> clip=1 and stays 1; peak_abs=65536; mean_sq=0xFFFFFFFF (saturated).
- Drop enable after 20 samples, re-enable, feed 32 samples of 5 -> no pulse for the partial window; mean_sq=25 after a fresh SETTLE phase.
- Assert reset for one cycle mid-window -> all outputs 0 next cycle and the state is IDLE; no data_valid until a full new window completes.

Source files
------------

// File: rtl/power_window_accumulator.sv
// power_window_accumulator
// Windowed signal-power and peak detector for the mean-removed sample stream.
// Every 2^LOG2_N accepted samples it publishes the saturated mean of squares
// and the peak |x| with a one-cycle data_valid pulse. After each enable rise
// the first SETTLE strobed samples are discarded while upstream settles.
//
// Handshake: there is no back-pressure. A sample is taken in every cycle where
// CE=1, but only while the FSM is in RUN with enable=1. data_valid is a
// single-cycle pulse, and mean_sq/peak_abs hold their value until the next pulse.
module power_window_accumulator #(
  parameter int LOG2_N = 5,
  parameter int SETTLE = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] data_in,
  input  logic        CE,
  output logic [31:0] mean_sq,
  output logic [16:0] peak_abs,
  output logic        data_valid,
  output logic        clip,
  output logic        busy
);

  localparam int ACC_W = 34 + LOG2_N;
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic start;
  logic accept;
  logic flush;

  logic [31:0]       settle_cnt;
  logic [LOG2_N-1:0] sample_cnt;

  // S1 registers
  logic               s1_valid;
  logic               s1_last;
  logic signed [16:0] s1_x;

  // S2 registers
  logic        s2_valid;
  logic        s2_last;
  logic [33:0] s2_sq;
  logic [16:0] s2_abs;

  // S3 window state
  logic [ACC_W-1:0] acc;
  logic [16:0]      peak;

  // Input saturation to the 17-bit signed range
  logic signed [31:0] din_s;
  logic               sat_hi;
  logic               sat_lo;
  logic [16:0]        x_sat;

  // Square and magnitude of the S1 sample
  logic signed [33:0] prod;
  logic [16:0]        x_abs;

  // Window completion arithmetic
  logic [ACC_W-1:0]        sum;
  logic [ACC_W-LOG2_N-1:0] mean_full;
  logic [16:0]             peak_next;

  assign busy = (state != IDLE);

  assign din_s  = signed'(data_in);
  assign sat_hi = (din_s > 32'sd65535);
  assign sat_lo = (din_s < -32'sd65536);
  assign x_sat  = sat_hi ? 17'h0FFFF : (sat_lo ? 17'h10000 : data_in[16:0]);

  assign prod  = s1_x * s1_x;
  assign x_abs = s1_x[16] ? 17'(-s1_x) : unsigned'(s1_x);

  assign sum       = acc + ACC_W'(s2_sq);
  assign mean_full = sum[ACC_W-1:LOG2_N];
  assign peak_next = (s2_abs > peak) ? s2_abs : peak;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    next_state = state;
    start      = 1'b0;
    accept     = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          start      = 1'b1;
          next_state = (SETTLE > 0) ? SETTLING : RUN;
        end
      end
      SETTLING: begin
        if (!enable) begin
          flush      = 1'b1;
          next_state = IDLE;
        end else if (CE && (settle_cnt == SETTLE_LAST)) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          flush      = 1'b1;
          next_state = IDLE;
        end else begin
          accept = CE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Settle counter: counts strobes discarded while upstream settles
  always_ff @(posedge clock) begin
    if (reset || start) settle_cnt <= '0;
    else if ((state == SETTLING) && enable && CE) settle_cnt <= settle_cnt + 32'd1;
  end

  // S1: saturate, flag clipping, tag the last sample of each window
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_x       <= '0;
      sample_cnt <= '0;
      clip       <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (start) begin
        sample_cnt <= '0;
        clip       <= 1'b0;
      end else if (accept) begin
        s1_x       <= signed'(x_sat);
        s1_last    <= &sample_cnt;
        sample_cnt <= sample_cnt + 1'b1;
        if (sat_hi || sat_lo) clip <= 1'b1;
      end
    end
  end

  // S2: square and magnitude; an enable drop kills the in-flight sample
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_sq    <= '0;
      s2_abs   <= '0;
    end else begin
      s2_valid <= s1_valid && !flush;
      s2_last  <= s1_last;
      s2_sq    <= unsigned'(prod);
      s2_abs   <= x_abs;
    end
  end

  // S3: accumulate, track peak, publish and restart on the last sample
  always_ff @(posedge clock) begin
    if (reset) begin
      acc        <= '0;
      peak       <= '0;
      mean_sq    <= '0;
      peak_abs   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (s2_valid) begin
        if (s2_last) begin
          acc        <= '0;
          peak       <= '0;
          mean_sq    <= (|mean_full[ACC_W-LOG2_N-1:32]) ? 32'hFFFF_FFFF : mean_full[31:0];
          peak_abs   <= peak_next;
          data_valid <= 1'b1;
        end else begin
          acc  <= sum;
          peak <= peak_next;
        end
      end else if (start) begin
        acc  <= '0;
        peak <= '0;
      end
    end
  end

endmodule
